// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Non-blocking, write-back, 2-way set-associative data cache
//             controller with one 32-bit word per line. Serves load/store
//             requests from the memory stage, answers hits in one cycle,
//             hands misses and dirty-victim writebacks to the downstream
//             MSHR and installs MSHR refills, writing refilled load data
//             back to the register file.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              clock, asynchronous active-high reset
//    i_req_*               memory-stage request (valid, we, addr, wdata, rd)
//    o_stall               request not accepted this cycle (combinational)
//    o_hit_*               registered load-hit response
//    o_load_valid/...      load request to the MSHR (combinational)
//    o_evict_valid/...     write to memory: dirty victim or store miss
//    i_addr1..i_addr4      MSHR in-flight addresses (32'hDEAD_BEEF = empty)
//    i_full                MSHR cannot accept another entry
//    i_addr_out/...        refill from the MSHR, valid on i_done_pulse
//    o_rf_*                registered register-file write of refilled data
// ============================================================================
module dcache_ctrl #(
  parameter int SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  // memory-stage request
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_stall,
  // load-hit response
  output logic        o_hit_valid,
  output logic [4:0]  o_hit_rd,
  output logic [31:0] o_hit_data,
  // to the MSHR
  output logic        o_load_valid,
  output logic [31:0] o_addr_load,
  output logic        o_load_way_in,
  output logic [4:0]  o_regD_in,
  output logic        o_evict_valid,
  output logic [31:0] o_addr_evict,
  output logic [31:0] o_evict_data,
  // from the MSHR
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_addr2,
  input  logic [31:0] i_addr3,
  input  logic [31:0] i_addr4,
  input  logic        i_full,
  input  logic [31:0] i_addr_out,
  input  logic [31:0] i_data_out,
  input  logic [4:0]  i_regD_out,
  input  logic        i_load_way_out,
  input  logic        i_done_pulse,
  // register-file refill write
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  // --------------------------------------------------------------------------
  // Storage: status bits are packed per set so they can be cleared by reset;
  // tag and data arrays carry no reset since valid gates every use of them.
  // --------------------------------------------------------------------------
  logic [SETS-1:0][1:0]  r_valid;
  logic [SETS-1:0][1:0]  r_dirty;
  logic [SETS-1:0][1:0]  r_pend;
  logic [SETS-1:0]       r_lru;     // names the least-recently-used way
  logic [TAG_BITS-1:0]   r_tag  [SETS][2];
  logic [31:0]           r_data [SETS][2];

  logic                  r_hit_valid;
  logic [4:0]            r_hit_rd;
  logic [31:0]           r_hit_data;
  logic                  r_rf_we;
  logic [4:0]            r_rf_rd;
  logic [31:0]           r_rf_data;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [31:0]           w_wa;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_ref_idx;
  logic [TAG_BITS-1:0]   w_ref_tag;
  logic                  w_unused;

  assign w_wa      = {i_req_addr[31:2], 2'b00};
  assign w_idx     = i_req_addr[INDEX_BITS+1:2];
  assign w_tag     = i_req_addr[31:INDEX_BITS+2];
  assign w_ref_idx = i_addr_out[INDEX_BITS+1:2];
  assign w_ref_tag = i_addr_out[31:INDEX_BITS+2];
  // Byte offsets are word-aligned away and carry no information.
  assign w_unused  = &{1'b0, i_req_addr[1:0], i_addr_out[1:0]};

  // --------------------------------------------------------------------------
  // Tag compare per way; a pending way is never a hit even if its old tag
  // happens to match, because its contents are being replaced.
  // --------------------------------------------------------------------------
  logic [1:0] w_way_hit;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign w_way_hit[w] = r_valid[w_idx][w] && !r_pend[w_idx][w] &&
                          (r_tag[w_idx][w] == w_tag);
  end

  logic w_hit;
  logic w_hit_way;

  assign w_hit     = |w_way_hit;
  assign w_hit_way = w_way_hit[1];

  // --------------------------------------------------------------------------
  // Victim selection for a load miss
  // --------------------------------------------------------------------------
  logic [1:0] w_set_pend;
  logic [1:0] w_set_val;
  logic       w_set_lru;
  logic       w_vic;
  logic       w_vic_ok;

  assign w_set_pend = r_pend[w_idx];
  assign w_set_val  = r_valid[w_idx];
  assign w_set_lru  = r_lru[w_idx];

  always_comb begin
    w_vic    = 1'b0;
    w_vic_ok = 1'b1;
    if (!w_set_pend[0] && !w_set_val[0]) begin
      w_vic = 1'b0;
    end else if (!w_set_pend[1] && !w_set_val[1]) begin
      w_vic = 1'b1;
    end else if (!w_set_pend[w_set_lru]) begin
      w_vic = w_set_lru;
    end else if (!w_set_pend[~w_set_lru]) begin
      w_vic = ~w_set_lru;
    end else begin
      w_vic_ok = 1'b0;
    end
  end

  logic w_vic_dirty;

  assign w_vic_dirty = w_set_val[w_vic] && r_dirty[w_idx][w_vic];

  // --------------------------------------------------------------------------
  // Acceptance. A same-set refill stalls the request so the arrays never see
  // two writes to one set in a cycle. The empty sentinel cannot match w_wa
  // because its low bits are non-zero.
  // --------------------------------------------------------------------------
  logic w_mshr_match;
  logic w_ref_conflict;
  logic w_no_victim;
  logic w_stall;
  logic w_go;

  assign w_mshr_match   = (w_wa == i_addr1) || (w_wa == i_addr2) ||
                          (w_wa == i_addr3) || (w_wa == i_addr4);
  assign w_ref_conflict = i_done_pulse && (w_ref_idx == w_idx);
  assign w_no_victim    = !i_req_we && !w_hit && !w_vic_ok;
  assign w_stall        = i_req_valid &&
                          (i_full || w_mshr_match || w_ref_conflict || w_no_victim);
  assign w_go           = i_req_valid && !w_stall;

  logic w_ld_hit;
  logic w_st_hit;
  logic w_ld_miss;
  logic w_st_miss;

  assign w_ld_hit  = w_go && !i_req_we &&  w_hit;
  assign w_st_hit  = w_go &&  i_req_we &&  w_hit;
  assign w_ld_miss = w_go && !i_req_we && !w_hit;
  assign w_st_miss = w_go &&  i_req_we && !w_hit;

  // --------------------------------------------------------------------------
  // MSHR-facing outputs, zero unless a miss is being issued
  // --------------------------------------------------------------------------
  always_comb begin
    o_load_valid  = 1'b0;
    o_addr_load   = 32'h0;
    o_load_way_in = 1'b0;
    o_regD_in     = 5'h0;
    o_evict_valid = 1'b0;
    o_addr_evict  = 32'h0;
    o_evict_data  = 32'h0;
    if (w_ld_miss) begin
      o_load_valid  = 1'b1;
      o_addr_load   = w_wa;
      o_load_way_in = w_vic;
      o_regD_in     = i_req_rd;
      if (w_vic_dirty) begin
        o_evict_valid = 1'b1;
        o_addr_evict  = {r_tag[w_idx][w_vic], w_idx, 2'b00};
        o_evict_data  = r_data[w_idx][w_vic];
      end
    end else if (w_st_miss) begin
      // No write-allocate: the store goes straight to memory.
      o_evict_valid = 1'b1;
      o_addr_evict  = w_wa;
      o_evict_data  = i_req_wdata;
    end
  end

  assign o_stall = w_stall;

  // --------------------------------------------------------------------------
  // Status bits and registered responses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_pend      <= '0;
      r_lru       <= '0;
      r_hit_valid <= 1'b0;
      r_hit_rd    <= 5'h0;
      r_hit_data  <= 32'h0;
      r_rf_we     <= 1'b0;
      r_rf_rd     <= 5'h0;
      r_rf_data   <= 32'h0;
    end else begin
      if (i_done_pulse) begin
        r_valid[w_ref_idx][i_load_way_out] <= 1'b1;
        r_dirty[w_ref_idx][i_load_way_out] <= 1'b0;
        r_pend[w_ref_idx][i_load_way_out]  <= 1'b0;
        r_lru[w_ref_idx]                   <= ~i_load_way_out;
      end
      if (w_ld_hit || w_st_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
      end
      if (w_st_hit) begin
        r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_ld_miss) begin
        // Victim is reserved for the refill; its writeback already left above.
        r_valid[w_idx][w_vic] <= 1'b0;
        r_dirty[w_idx][w_vic] <= 1'b0;
        r_pend[w_idx][w_vic]  <= 1'b1;
      end

      r_hit_valid <= w_ld_hit;
      if (w_ld_hit) begin
        r_hit_rd   <= i_req_rd;
        r_hit_data <= r_data[w_idx][w_hit_way];
      end

      r_rf_we <= i_done_pulse;
      if (i_done_pulse) begin
        r_rf_rd   <= i_regD_out;
        r_rf_data <= i_data_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag and data arrays
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_done_pulse) begin
      r_tag[w_ref_idx][i_load_way_out]  <= w_ref_tag;
      r_data[w_ref_idx][i_load_way_out] <= i_data_out;
    end
    if (w_st_hit) begin
      r_data[w_idx][w_hit_way] <= i_req_wdata;
    end
  end

  assign o_hit_valid = r_hit_valid;
  assign o_hit_rd    = r_hit_rd;
  assign o_hit_data  = r_hit_data;
  assign o_rf_we     = r_rf_we;
  assign o_rf_rd     = r_rf_rd;
  assign o_rf_data   = r_rf_data;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Directed, table-driven self-checking bench for dcache_ctrl,
//             with hand-written sequences for asynchronous reset mid-miss.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  localparam logic [31:0] C_EMPTY = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [4:0]  i_req_rd;
  logic        o_stall;
  logic        o_hit_valid;
  logic [4:0]  o_hit_rd;
  logic [31:0] o_hit_data;
  logic        o_load_valid;
  logic [31:0] o_addr_load;
  logic        o_load_way_in;
  logic [4:0]  o_regD_in;
  logic        o_evict_valid;
  logic [31:0] o_addr_evict;
  logic [31:0] o_evict_data;
  logic [31:0] i_addr1;
  logic [31:0] i_addr2;
  logic [31:0] i_addr3;
  logic [31:0] i_addr4;
  logic        i_full;
  logic [31:0] i_addr_out;
  logic [31:0] i_data_out;
  logic [4:0]  i_regD_out;
  logic        i_load_way_out;
  logic        i_done_pulse;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_data;

  dcache_ctrl #(.SETS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_we       (i_req_we),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .i_req_rd       (i_req_rd),
    .o_stall        (o_stall),
    .o_hit_valid    (o_hit_valid),
    .o_hit_rd       (o_hit_rd),
    .o_hit_data     (o_hit_data),
    .o_load_valid   (o_load_valid),
    .o_addr_load    (o_addr_load),
    .o_load_way_in  (o_load_way_in),
    .o_regD_in      (o_regD_in),
    .o_evict_valid  (o_evict_valid),
    .o_addr_evict   (o_addr_evict),
    .o_evict_data   (o_evict_data),
    .i_addr1        (i_addr1),
    .i_addr2        (i_addr2),
    .i_addr3        (i_addr3),
    .i_addr4        (i_addr4),
    .i_full         (i_full),
    .i_addr_out     (i_addr_out),
    .i_data_out     (i_data_out),
    .i_regD_out     (i_regD_out),
    .i_load_way_out (i_load_way_out),
    .i_done_pulse   (i_done_pulse),
    .o_rf_we        (o_rf_we),
    .o_rf_rd        (o_rf_rd),
    .o_rf_data      (o_rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the expected combinational outputs in that
  // cycle and the expected registered outputs after the following edge.
  typedef struct {
    logic [31:0] v, we, addr, wdata, rd, a1, full;
    logic [31:0] dn, aout, dout, rdo, wo;
    logic [31:0] e_stall, e_lv, e_al, e_lw, e_ev, e_ae, e_de;
    logic [31:0] e_hv, e_hrd, e_hd;
    logic [31:0] e_rf, e_rfrd, e_rfd;
  } vec_t;

  vec_t tbl [30];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    i_req_valid    = t.v[0];
    i_req_we       = t.we[0];
    i_req_addr     = t.addr;
    i_req_wdata    = t.wdata;
    i_req_rd       = t.rd[4:0];
    i_addr1        = t.a1;
    i_full         = t.full[0];
    i_done_pulse   = t.dn[0];
    i_addr_out     = t.aout;
    i_data_out     = t.dout;
    i_regD_out     = t.rdo[4:0];
    i_load_way_out = t.wo[0];
  endtask

  task automatic run(input vec_t t, input int n);
    drive(t);
    #1;
    chk($sformatf("v%0d stall", n),       32'(o_stall),       t.e_stall);
    chk($sformatf("v%0d load_valid", n),  32'(o_load_valid),  t.e_lv);
    chk($sformatf("v%0d addr_load", n),   o_addr_load,        t.e_al);
    chk($sformatf("v%0d load_way_in", n), 32'(o_load_way_in), t.e_lw);
    chk($sformatf("v%0d regD_in", n),     32'(o_regD_in),     (t.e_lv != 0) ? t.rd : 32'h0);
    chk($sformatf("v%0d evict_valid", n), 32'(o_evict_valid), t.e_ev);
    chk($sformatf("v%0d addr_evict", n),  o_addr_evict,       t.e_ae);
    chk($sformatf("v%0d evict_data", n),  o_evict_data,       t.e_de);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d hit_valid", n), 32'(o_hit_valid), t.e_hv);
    if (t.e_hv != 0) begin
      chk($sformatf("v%0d hit_rd", n),   32'(o_hit_rd), t.e_hrd);
      chk($sformatf("v%0d hit_data", n), o_hit_data,    t.e_hd);
    end
    chk($sformatf("v%0d rf_we", n), 32'(o_rf_we), t.e_rf);
    if (t.e_rf != 0) begin
      chk($sformatf("v%0d rf_rd", n),   32'(o_rf_rd), t.e_rfrd);
      chk($sformatf("v%0d rf_data", n), o_rf_data,    t.e_rfd);
    end
    @(negedge clk);
  endtask

  initial begin
    // Fields: v we addr wdata rd | a1 full | dn aout dout rdo wo |
    //         stall lv al lw ev ae de | hv hrd hd | rf rfrd rfd
    // Cold miss, refill, then hit on set 0.
    tbl[0]  = '{0,0,0,0,0,        C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[1]  = '{1,0,'h40,0,5,     C_EMPTY,0, 0,0,0,0,0,             0,1,'h40,0,0,0,0,         0,0,0,         0,0,0};
    tbl[2]  = '{0,0,0,0,0,        C_EMPTY,0, 1,'h40,'h1234,5,0,     0,0,0,0,0,0,0,            0,0,0,         1,5,'h1234};
    tbl[3]  = '{1,0,'h40,0,6,     C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            1,6,'h1234,    0,0,0};
    // Fill way 1, dirty way 0, make way 0 LRU, then evict it.
    tbl[4]  = '{1,0,'h80,0,7,     C_EMPTY,0, 0,0,0,0,0,             0,1,'h80,1,0,0,0,         0,0,0,         0,0,0};
    tbl[5]  = '{0,0,0,0,0,        C_EMPTY,0, 1,'h80,'hBBBB,7,1,     0,0,0,0,0,0,0,            0,0,0,         1,7,'hBBBB};
    tbl[6]  = '{1,1,'h40,'hAAAA,0,C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[7]  = '{1,0,'h80,0,8,     C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            1,8,'hBBBB,    0,0,0};
    tbl[8]  = '{1,0,'hC0,0,9,     C_EMPTY,0, 0,0,0,0,0,             0,1,'hC0,0,1,'h40,'hAAAA, 0,0,0,         0,0,0};
    // Store miss bypasses the cache; the following load still misses.
    tbl[9]  = '{1,1,'h100,'h55,0, C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,1,'h100,'h55,     0,0,0,         0,0,0};
    tbl[10] = '{1,0,'h100,0,10,   C_EMPTY,0, 0,0,0,0,0,             0,1,'h100,1,0,0,0,        0,0,0,         0,0,0};
    // Both ways pending: stall, then same-set refill keeps it stalled.
    tbl[11] = '{1,0,'h440,0,11,   C_EMPTY,0, 0,0,0,0,0,             1,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[12] = '{1,0,'h440,0,11,   C_EMPTY,0, 1,'hC0,'hCCCC,9,0,     1,0,0,0,0,0,0,            0,0,0,         1,9,'hCCCC};
    tbl[13] = '{1,0,'h440,0,11,   C_EMPTY,0, 0,0,0,0,0,             0,1,'h440,0,0,0,0,        0,0,0,         0,0,0};
    tbl[14] = '{0,0,0,0,0,        C_EMPTY,0, 1,'h100,'h1010,10,1,   0,0,0,0,0,0,0,            0,0,0,         1,10,'h1010};
    // MSHR full, MSHR address match on a would-be hit, then the hit.
    tbl[15] = '{1,0,'h200,0,12,   C_EMPTY,1, 0,0,0,0,0,             1,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[16] = '{1,0,'h100,0,13,   'h100,0,   0,0,0,0,0,             1,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[17] = '{1,0,'h100,0,13,   C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            1,13,'h1010,   0,0,0};
    // Same-set refill stalls an otherwise-hitting request for one cycle.
    tbl[18] = '{1,0,'h100,0,13,   C_EMPTY,0, 1,'h440,'h4444,11,0,   1,0,0,0,0,0,0,            0,0,0,         1,11,'h4444};
    // Set 1 miss, then a set-1 refill in parallel with a set-0 hit.
    tbl[19] = '{1,0,'h44,0,14,    C_EMPTY,0, 0,0,0,0,0,             0,1,'h44,0,0,0,0,         0,0,0,         0,0,0};
    tbl[20] = '{1,0,'h440,0,15,   C_EMPTY,0, 1,'h44,'h4400,14,0,    0,0,0,0,0,0,0,            1,15,'h4444,   1,14,'h4400};
    // Byte offset ignored; miss fills the invalid way 1.
    tbl[21] = '{1,0,'h446,0,16,   C_EMPTY,0, 0,0,0,0,0,             0,1,'h444,1,0,0,0,        0,0,0,         0,0,0};
    tbl[22] = '{0,1,'h200,5,0,    C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            0,0,0,         0,0,0};
    // Dirty way 0 chosen because way 1 (LRU) is pending.
    tbl[23] = '{1,1,'h44,'h77,0,  C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[24] = '{1,0,'h84,0,17,    C_EMPTY,0, 0,0,0,0,0,             0,1,'h84,0,1,'h44,'h77,   0,0,0,         0,0,0};
    // After reset: in-flight repeat stalls until addr1 clears, then hits.
    tbl[25] = '{1,0,'h440,0,22,   C_EMPTY,0, 0,0,0,0,0,             0,1,'h440,0,0,0,0,        0,0,0,         0,0,0};
    tbl[26] = '{1,0,'h440,0,23,   'h440,0,   0,0,0,0,0,             1,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[27] = '{1,0,'h440,0,23,   'h440,0,   0,0,0,0,0,             1,0,0,0,0,0,0,            0,0,0,         0,0,0};
    tbl[28] = '{1,0,'h440,0,23,   'h440,0,   1,'h440,'h9999,22,0,   1,0,0,0,0,0,0,            0,0,0,         1,22,'h9999};
    tbl[29] = '{1,0,'h440,0,23,   C_EMPTY,0, 0,0,0,0,0,             0,0,0,0,0,0,0,            1,23,'h9999,   0,0,0};

    rst = 1'b1;
    drive(tbl[0]);
    i_addr2 = C_EMPTY;
    i_addr3 = C_EMPTY;
    i_addr4 = C_EMPTY;
    @(negedge clk);
    @(negedge clk);
    chk("reset hit_valid", 32'(o_hit_valid), 32'h0);
    chk("reset hit_data",  o_hit_data,       32'h0);
    chk("reset rf_we",     32'(o_rf_we),     32'h0);
    chk("reset rf_data",   o_rf_data,        32'h0);
    chk("reset stall",     32'(o_stall),     32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) run(tbl[i], i);

    // Asynchronous reset while a hit response is showing and set 1 has
    // two misses pending with a dirty line gone to memory.
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h440;
    i_req_rd    = 5'd20;
    #1;
    chk("pre-reset stall", 32'(o_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("pre-reset hit_valid", 32'(o_hit_valid), 32'h1);
    chk("pre-reset hit_data",  o_hit_data,       32'h4444);
    rst = 1'b1;
    #1;
    chk("async reset hit_valid", 32'(o_hit_valid), 32'h0);
    chk("async reset hit_data",  o_hit_data,       32'h0);
    chk("async reset hit_rd",    32'(o_hit_rd),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    // Set 1 pending/dirty state is gone: a fresh miss takes way 0, no evict.
    i_req_addr = 32'h84;
    i_req_rd   = 5'd21;
    #1;
    chk("post-reset stall",       32'(o_stall),       32'h0);
    chk("post-reset load_valid",  32'(o_load_valid),  32'h1);
    chk("post-reset load_way_in", 32'(o_load_way_in), 32'h0);
    chk("post-reset evict_valid", 32'(o_evict_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 25; i < 30; i++) run(tbl[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
